// File: rtl/fetch_queue.sv
// Decoupling FIFO between the frontend and id_stage, flushed as a whole on a pipeline flush.
// Optional fall-through when empty: define FETCH_QUEUE_BYPASS_EN.

package fetch_queue_pkg;
    typedef struct packed {
        logic [31:0] address;
        logic [31:0] instruction;
        logic        is_compressed;
        logic        ex_valid;
    } frontend_fetch_t;
endpackage

module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,
    input  frontend_fetch_t             fetch_entry_i,
    input  logic                        fetch_entry_valid_i,
    output logic                        fetch_entry_ready_o,
    output frontend_fetch_t             fetch_entry_o,
    output logic                        fetch_entry_valid_o,
    input  logic                        fetch_ack_i,
    output logic [$clog2(DEPTH):0]      usage_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    frontend_fetch_t  mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic write_en;
    logic pop_stored;

    // Handshakes: an entry moves in on valid_i & ready_o and out on valid_o & ack_i,
    // both at the rising clock edge. ready_o comes from registered count only, so a
    // pop while full frees the slot one cycle later; ack_i without valid_o is ignored.
    assign empty               = (count_q == '0);
    assign full                = (count_q == FULL_CNT);
    assign fetch_entry_ready_o = !full;
    assign push                = fetch_entry_valid_i & fetch_entry_ready_o;
    assign pop                 = fetch_entry_valid_o & fetch_ack_i;
    assign usage_o             = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass;

    // When empty, the incoming entry falls through; if acked at once it is never stored.
    assign bypass              = empty & fetch_entry_valid_i;
    assign fetch_entry_valid_o = !empty | fetch_entry_valid_i;
    assign fetch_entry_o       = bypass ? fetch_entry_i : mem_q[rd_ptr_q];
    assign write_en            = push & ~(bypass & fetch_ack_i);
    assign pop_stored          = pop & ~empty;
`else
    assign fetch_entry_valid_o = !empty;
    assign fetch_entry_o       = mem_q[rd_ptr_q];
    assign write_en            = push;
    assign pop_stored          = pop;
`endif

    always_comb begin
        count_d = count_q + CNT_W'(write_en) - CNT_W'(pop_stored);
    end

    // Storage survives a flush; only the pointers and count are cleared.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (write_en && !flush_i) begin
            mem_q[wr_ptr_q] <= fetch_entry_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (write_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_stored) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

endmodule
